// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD result display path: HD44780
// command bytes, ASCII codes, CPU opcodes, controller state encodings and
// a couple of character helpers.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
   localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_LINE1      = 8'h80;
   localparam logic [7:0] CMD_LINE2      = 8'hC0;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_R     = 8'h52;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SUBI = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;
   localparam logic [2:0] OP_DPL  = 3'b111;

   typedef enum logic [2:0] {
      ST_PWRUP_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_CONVERT,
      ST_SEND
   } state_e;

   // Sub-phases of a single LCD byte write.
   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_WAIT
   } phase_e;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

   // Character k (0 = leftmost) of the 4-character mnemonic for an opcode.
   function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [1:0] k);
      logic [31:0] word;
      case (op)
         OP_LOAD: word = "LOAD";
         OP_ADD:  word = "ADD ";
         OP_ADDI: word = "ADDI";
         OP_SUB:  word = "SUB ";
         OP_SUBI: word = "SUBI";
         OP_MUL:  word = "MUL ";
         OP_DPL:  word = "DPL ";
         default: word = "    ";
      endcase
      case (k)
         2'd0:    return word[31:24];
         2'd1:    return word[23:16];
         2'd2:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 17-bit binary to five BCD digits.
// One bit per clock; done_o pulses 18 cycles after start_i and bcd_o then
// holds the result until the next start.
module bin2bcd_seq (
   input  logic        clock_50mhz,
   input  logic        botao_reset_ligar,
   input  logic        start_i,
   input  logic [16:0] bin_i,
   output logic        done_o,
   output logic [19:0] bcd_o
);

   logic [16:0] bin_q, bin_d;
   logic [19:0] bcd_q, bcd_d, adj;
   logic [4:0]  cnt_q;
   logic        run_q, done_q;

   // One add-3-then-shift step of the double-dabble algorithm.
   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < 5; k++) begin
         if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
      bcd_d = {adj[18:0], bin_q[16]};
      bin_d = {bin_q[15:0], 1'b0};
   end

   // Load on start, then shift 17 times and flag completion.
   always_ff @(posedge clock_50mhz or negedge botao_reset_ligar) begin
      if (!botao_reset_ligar) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         bin_q  <= bin_i;
         bcd_q  <= '0;
         cnt_q  <= 5'd17;
         run_q  <= 1'b1;
         done_q <= 1'b0;
      end else if (run_q) begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_q - 5'd1;
         run_q  <= (cnt_q != 5'd1);
         done_q <= (cnt_q == 5'd1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/lcd_display_ctrl.sv
// Result display controller for an HD44780 16x2 LCD in 8-bit mode.
// Takes one request per CPU instruction, renders mnemonic/register on line 1
// and signed decimal value on line 2, and hands busy/done back to the CPU.
//
// state          | meaning
// ST_PWRUP_WAIT  | LCD power-up delay, bus idle
// ST_INIT        | writing the four init commands
// ST_IDLE        | ready, busy=0, waiting for req_valid
// ST_CONVERT     | magnitude to BCD in progress
// ST_SEND        | writing frame bytes (or the single clear command)
//
// Each byte runs PH_SETUP (1 cycle) -> PH_PULSE (en high) -> PH_WAIT (en low).
module lcd_display_ctrl
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC    = 1_000_000,
   parameter int EN_PULSE_CYC   = 25,
   parameter int CHAR_WAIT_CYC  = 2_500,
   parameter int CLEAR_WAIT_CYC = 100_000
) (
   input  logic        clock_50mhz,
   input  logic        botao_reset_ligar,
   input  logic        req_valid,
   input  logic [2:0]  req_opcode,
   input  logic [3:0]  req_reg_addr,
   input  logic [15:0] req_value,
   output logic        busy,
   output logic        done,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en,
   output logic        lcd_on,
   output logic        lcd_blon
);

   localparam int TMAX_A = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int TMAX_B = (EN_PULSE_CYC > CHAR_WAIT_CYC) ? EN_PULSE_CYC : CHAR_WAIT_CYC;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [5:0] LAST_INIT  = 6'd3;
   localparam logic [5:0] LAST_FRAME = 6'd33;

   state_e          state_q, state_d;
   phase_e          phase_q, phase_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [5:0]      idx_q, idx_d;

   logic [2:0]      op_q;
   logic [3:0]      reg_q;
   logic [15:0]     value_q;
   logic            start_q, done_q;

   logic            accept, frame_end, bcd_done, is_clear, byte_active;
   logic [5:0]      last_idx;
   logic [16:0]     value_sx, magnitude;
   logic [19:0]     bcd;
   logic [3:0]      pos1, pos2, reg_units;
   logic [7:0]      line1_char, line2_char, cur_data;
   logic            cur_rs;

   // Sign-extend before negating so 0x8000 yields 32768 rather than wrapping.
   assign value_sx  = {value_q[15], value_q};
   assign magnitude = value_q[15] ? (~value_sx + 17'd1) : value_sx;

   bin2bcd_seq u_bin2bcd (
      .clock_50mhz       (clock_50mhz),
      .botao_reset_ligar (botao_reset_ligar),
      .start_i           (start_q),
      .bin_i             (magnitude),
      .done_o            (bcd_done),
      .bcd_o             (bcd)
   );

   // Select the byte addressed by idx_q in the current state.
   always_comb begin
      pos1       = 4'(idx_q - 6'd1);
      pos2       = 4'(idx_q - 6'd18);
      reg_units  = (reg_q >= 4'd10) ? (reg_q - 4'd10) : reg_q;
      line1_char = ASCII_SPACE;
      if (pos1 <= 4'd3)      line1_char = mnemonic_char(op_q, pos1[1:0]);
      else if (pos1 == 4'd5) line1_char = ASCII_R;
      else if (pos1 == 4'd6) line1_char = ascii_digit((reg_q >= 4'd10) ? 4'd1 : 4'd0);
      else if (pos1 == 4'd7) line1_char = ascii_digit(reg_units);
      case (pos2)
         4'd0:    line2_char = value_q[15] ? ASCII_MINUS : ASCII_PLUS;
         4'd1:    line2_char = ascii_digit(bcd[19:16]);
         4'd2:    line2_char = ascii_digit(bcd[15:12]);
         4'd3:    line2_char = ascii_digit(bcd[11:8]);
         4'd4:    line2_char = ascii_digit(bcd[7:4]);
         4'd5:    line2_char = ascii_digit(bcd[3:0]);
         default: line2_char = ASCII_SPACE;
      endcase
      cur_data = 8'h00;
      cur_rs   = 1'b0;
      if (state_q == ST_INIT) begin
         case (idx_q)
            6'd0:    cur_data = CMD_FUNC_SET;
            6'd1:    cur_data = CMD_DISP_ON;
            6'd2:    cur_data = CMD_ENTRY_MODE;
            default: cur_data = CMD_CLEAR;
         endcase
      end else if (op_q == OP_CLR) begin
         cur_data = CMD_CLEAR;
      end else if (idx_q == 6'd0) begin
         cur_data = CMD_LINE1;
      end else if (idx_q <= 6'd16) begin
         cur_data = line1_char;
         cur_rs   = 1'b1;
      end else if (idx_q == 6'd17) begin
         cur_data = CMD_LINE2;
      end else begin
         cur_data = line2_char;
         cur_rs   = 1'b1;
      end
   end

   assign is_clear = !cur_rs && (cur_data == CMD_CLEAR);
   assign last_idx = (state_q == ST_INIT) ? LAST_INIT :
                     (op_q == OP_CLR)     ? 6'd0      : LAST_FRAME;

   // Control state register.
   always_ff @(posedge clock_50mhz or negedge botao_reset_ligar) begin
      if (!botao_reset_ligar) begin
         state_q <= ST_PWRUP_WAIT;
         phase_q <= PH_SETUP;
         timer_q <= TW'(POWERUP_CYC - 1);
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic: power-up delay, byte sequencing and request accept.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      timer_d   = timer_q;
      idx_d     = idx_q;
      accept    = 1'b0;
      frame_end = 1'b0;
      case (state_q)
         ST_PWRUP_WAIT: begin
            if (timer_q == '0) begin
               state_d = ST_INIT;
               phase_d = PH_SETUP;
               idx_d   = '0;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_INIT, ST_SEND: begin
            case (phase_q)
               PH_SETUP: begin
                  phase_d = PH_PULSE;
                  timer_d = TW'(EN_PULSE_CYC - 1);
               end
               PH_PULSE: begin
                  if (timer_q == '0) begin
                     phase_d = PH_WAIT;
                     timer_d = is_clear ? TW'(CLEAR_WAIT_CYC - 1) : TW'(CHAR_WAIT_CYC - 1);
                  end else begin
                     timer_d = timer_q - 1'b1;
                  end
               end
               default: begin
                  if (timer_q != '0) begin
                     timer_d = timer_q - 1'b1;
                  end else if (idx_q == last_idx) begin
                     state_d   = ST_IDLE;
                     frame_end = (state_q == ST_SEND);
                  end else begin
                     idx_d   = idx_q + 6'd1;
                     phase_d = PH_SETUP;
                  end
               end
            endcase
         end
         ST_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = (req_opcode == OP_CLR) ? ST_SEND : ST_CONVERT;
               phase_d = PH_SETUP;
               idx_d   = '0;
            end
         end
         ST_CONVERT: begin
            if (bcd_done) begin
               state_d = ST_SEND;
               phase_d = PH_SETUP;
               idx_d   = '0;
            end
         end
         default: state_d = ST_PWRUP_WAIT;
      endcase
   end

   // Request latch, converter kick-off and the registered done pulse.
   always_ff @(posedge clock_50mhz or negedge botao_reset_ligar) begin
      if (!botao_reset_ligar) begin
         op_q    <= '0;
         reg_q   <= '0;
         value_q <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         start_q <= accept && (req_opcode != OP_CLR);
         done_q  <= frame_end;
         if (accept) begin
            op_q    <= req_opcode;
            reg_q   <= req_reg_addr;
            value_q <= req_value;
         end
      end
   end

   // Drive the LCD bus and CPU handshake from the current state.
   always_comb begin
      byte_active = (state_q == ST_INIT) || (state_q == ST_SEND);
      busy        = (state_q != ST_IDLE);
      done        = done_q;
      lcd_en      = byte_active && (phase_q == PH_PULSE);
      lcd_data    = byte_active ? cur_data : 8'h00;
      lcd_rs      = byte_active && cur_rs;
      lcd_rw      = 1'b0;
      lcd_on      = 1'b1;
      lcd_blon    = 1'b1;
   end

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Directed bench for lcd_display_ctrl with shortened timing parameters.
module tb_lcd_display_ctrl;

   logic        clock_50mhz = 1'b0;
   logic        botao_reset_ligar = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_opcode = '0;
   logic [3:0]  req_reg_addr = '0;
   logic [15:0] req_value = '0;
   logic        busy, done;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

   int checks = 0;
   int failures = 0;

   int         cyc = 0;
   logic [7:0] q_data[$];
   logic       q_rs[$];
   int         q_width[$];
   int         q_rise[$];
   int         q_fall[$];
   int         done_cnt = 0;
   int         done_cyc = -1;
   int         busy_fall_cyc = -1;
   int         hi_cnt = 0;
   logic       en_prev = 1'b0;
   logic       busy_prev = 1'b1;

   always #10 clock_50mhz = ~clock_50mhz;

   lcd_display_ctrl #(
      .POWERUP_CYC    (100),
      .EN_PULSE_CYC   (4),
      .CHAR_WAIT_CYC  (10),
      .CLEAR_WAIT_CYC (50)
   ) dut (
      .clock_50mhz       (clock_50mhz),
      .botao_reset_ligar (botao_reset_ligar),
      .req_valid         (req_valid),
      .req_opcode        (req_opcode),
      .req_reg_addr      (req_reg_addr),
      .req_value         (req_value),
      .busy              (busy),
      .done              (done),
      .lcd_data          (lcd_data),
      .lcd_rs            (lcd_rs),
      .lcd_rw            (lcd_rw),
      .lcd_en            (lcd_en),
      .lcd_on            (lcd_on),
      .lcd_blon          (lcd_blon)
   );

   // Bus monitor: logs every enable pulse and handshake event 1 ns after each edge.
   always @(posedge clock_50mhz) begin
      #1;
      cyc++;
      if (lcd_en && !en_prev) begin
         q_data.push_back(lcd_data);
         q_rs.push_back(lcd_rs);
         q_rise.push_back(cyc);
         hi_cnt = 1;
      end else if (lcd_en) begin
         hi_cnt++;
      end
      if (!lcd_en && en_prev) begin
         q_width.push_back(hi_cnt);
         q_fall.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!busy && busy_prev) busy_fall_cyc = cyc;
      en_prev   = lcd_en;
      busy_prev = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      q_data.delete();
      q_rs.delete();
      q_width.delete();
      q_rise.delete();
      q_fall.delete();
      done_cnt      = 0;
      done_cyc      = -1;
      busy_fall_cyc = -1;
   endtask

   function automatic string pad16(input string s);
      string r = s;
      while (r.len() < 16) r = {r, " "};
      return r;
   endfunction

   function automatic int bad_widths();
      int n = 0;
      foreach (q_width[i]) if (q_width[i] != 4) n++;
      return n;
   endfunction

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clock_50mhz);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   // Present one request for a single clock, then scramble the inputs.
   task automatic issue(input logic [2:0] op, input logic [3:0] ra, input logic [15:0] v);
      req_opcode   = op;
      req_reg_addr = ra;
      req_value    = v;
      req_valid    = 1'b1;
      @(negedge clock_50mhz);
      req_valid    = 1'b0;
      req_opcode   = 3'($urandom);
      req_reg_addr = 4'($urandom);
      req_value    = 16'($urandom);
   endtask

   task automatic check_init(input int rel);
      logic [7:0] exp_b [4];
      logic [3:0] rs_bits;
      exp_b[0] = 8'h38;
      exp_b[1] = 8'h0C;
      exp_b[2] = 8'h06;
      exp_b[3] = 8'h01;
      wait_idle(1000, "init_timeout");
      check("init_nbytes", q_data.size(), 4);
      if (q_data.size() == 4) begin
         rs_bits = {q_rs[0], q_rs[1], q_rs[2], q_rs[3]};
         for (int i = 0; i < 4; i++) check($sformatf("init_byte%0d", i), {24'd0, q_data[i]}, {24'd0, exp_b[i]});
         check("init_rs", {28'd0, rs_bits}, 32'd0);
      end
      check("init_widths", bad_widths(), 0);
      check("init_first_rise", (q_rise.size() > 0) ? q_rise[0] - rel : -1, 101);
      check("init_busy_fall", (q_fall.size() > 0) ? busy_fall_cyc - q_fall[$] : -1, 50);
      check("init_no_done", done_cnt, 0);
   endtask

   task automatic check_frame(input string tag, input string l1, input string l2);
      logic [7:0] e;
      logic       e_rs;
      check({tag, "_nbytes"}, q_data.size(), 34);
      for (int i = 0; i < 34 && i < q_data.size(); i++) begin
         if (i == 0)       e = 8'h80;
         else if (i < 17)  e = l1[i-1];
         else if (i == 17) e = 8'hC0;
         else              e = l2[i-18];
         e_rs = !(i == 0 || i == 17);
         check($sformatf("%s_b%0d", tag, i), {23'd0, q_rs[i], q_data[i]}, {23'd0, e_rs, e});
      end
      check({tag, "_widths"}, bad_widths(), 0);
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   task automatic run_frame(input string tag, input logic [2:0] op, input logic [3:0] ra,
                            input logic [15:0] v, input string l1, input string l2);
      clear_mon();
      issue(op, ra, v);
      wait_idle(3000, {tag, "_timeout"});
      check_frame(tag, pad16(l1), pad16(l2));
   endtask

   initial begin
      int rel;
      int n;
      repeat (3) @(negedge clock_50mhz);
      check("rst_outputs", {17'd0, busy, done, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon},
            {17'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

      clear_mon();
      rel = cyc;
      botao_reset_ligar = 1'b1;
      check_init(rel);

      run_frame("add", 3'b001, 4'd3, 16'h0007, "ADD  R03", "+00007");
      run_frame("load_min", 3'b000, 4'd15, 16'h8000, "LOAD R15", "-32768");
      run_frame("load_m1", 3'b000, 4'd15, 16'hFFFF, "LOAD R15", "-00001");
      run_frame("load_zero", 3'b000, 4'd15, 16'h0000, "LOAD R15", "+00000");
      run_frame("dpl", 3'b111, 4'd10, 16'h3039, "DPL  R10", "+12345");

      clear_mon();
      issue(3'b110, 4'd5, 16'h1234);
      wait_idle(1000, "clr_timeout");
      check("clr_nbytes", q_data.size(), 1);
      if (q_data.size() == 1) check("clr_byte", {23'd0, q_rs[0], q_data[0]}, 32'h001);
      check("clr_widths", bad_widths(), 0);
      check("clr_done_delay", (q_fall.size() > 0) ? done_cyc - q_fall[0] : -1, 50);
      check("clr_done_cnt", done_cnt, 1);

      clear_mon();
      issue(3'b100, 4'd9, 16'hCFC7);
      repeat (100) @(negedge clock_50mhz);
      check("mid_busy", {31'd0, busy}, 32'd1);
      issue(3'b010, 4'd1, 16'h0001);
      wait_idle(3000, "mid_timeout");
      check_frame("mid", pad16("SUBI R09"), pad16("-12345"));

      clear_mon();
      issue(3'b011, 4'd2, 16'h0005);
      n = 0;
      while (q_data.size() < 10 && n < 2000) begin
         @(negedge clock_50mhz);
         n++;
      end
      check("rst_mid_reached", q_data.size(), 10);
      check("rst_mid_en_before", {31'd0, lcd_en}, 32'd1);
      botao_reset_ligar = 1'b0;
      #1;
      check("rst_mid_en", {31'd0, lcd_en}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd1);
      repeat (5) @(negedge clock_50mhz);
      check("rst_mid_no_done", done_cnt, 0);
      clear_mon();
      rel = cyc;
      botao_reset_ligar = 1'b1;
      check_init(rel);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
